// File: rtl/ca_pkg.sv
// Shared state encoding, derived-size helpers and parameter legality checks
// for the cellular-automaton row writer.
package ca_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACK   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACK   = ST_ACK,
    WRITE = ST_WRITE
  } state_t;

  function automatic int calc_wpr(input int row_w, input int word_w);
    return row_w / word_w;
  endfunction

  function automatic int calc_addr_w(input int row_w, input int word_w, input int rows);
    return $clog2(rows * (row_w / word_w));
  endfunction

  function automatic int calc_ridx_w(input int rows);
    return $clog2(rows);
  endfunction

  // A one-word row still needs a 1-bit word counter.
  function automatic int calc_widx_w(input int wpr);
    return (wpr > 1) ? $clog2(wpr) : 1;
  endfunction

  function automatic bit params_ok(input int row_w, input int word_w, input int rows);
    return (word_w > 0) && (row_w >= word_w) && (row_w % word_w == 0) && (rows >= 2);
  endfunction

endpackage

// File: rtl/ca_row_writer.sv
// Captures one CA generation per load request and streams it, word by word,
// into a circular frame buffer whose oldest row is reported on top_row.
//
// state | meaning
// IDLE  | waiting for load; ca_row is captured on the edge load is seen
// ACK   | one-cycle ack to the core; first word is staged for the next cycle
// WRITE | presenting words to the frame buffer, holding while fb_ready=0
module ca_row_writer
  import ca_pkg::*;
#(
  parameter int ROW_W  = 512,
  parameter int WORD_W = 32,
  parameter int ROWS   = 512,
  localparam int WPR    = calc_wpr(ROW_W, WORD_W),
  localparam int ADDR_W = calc_addr_w(ROW_W, WORD_W, ROWS),
  localparam int RIDX_W = calc_ridx_w(ROWS),
  localparam int WIDX_W = calc_widx_w(WPR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ROW_W-1:0]  ca_row,
  output logic              ack,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [WORD_W-1:0] fb_wdata,
  input  logic              fb_ready,
  output logic [RIDX_W-1:0] top_row,
  output logic              frame_done,
  output logic              busy
);

  if (!params_ok(ROW_W, WORD_W, ROWS)) begin : g_bad_params
    $error("ca_row_writer: ROW_W must be a multiple of WORD_W and ROWS must be >= 2");
  end

  state_t             state;
  logic [ROW_W-1:0]   row_sr;
  logic [WIDX_W-1:0]  word;
  logic [RIDX_W-1:0]  wr_row;
  logic               wrapped;
  logic               last_word;
  logic               row_wrap;
  logic [RIDX_W-1:0]  next_row;

  assign last_word = (word == WIDX_W'(WPR - 1));
  assign row_wrap  = (wr_row == RIDX_W'(ROWS - 1));
  assign next_row  = row_wrap ? '0 : wr_row + RIDX_W'(1);
  assign busy      = (state != IDLE);

  // The shift register always holds the next word to present in its low slice,
  // so the data path needs no variable part-select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      row_sr     <= '0;
      word       <= '0;
      wr_row     <= '0;
      wrapped    <= 1'b0;
      top_row    <= '0;
      ack        <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      frame_done <= 1'b0;
    end else begin
      ack        <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            row_sr <= ca_row;
            word   <= '0;
            ack    <= 1'b1;
            state  <= ACK;
          end
        end
        ACK: begin
          fb_we    <= 1'b1;
          fb_addr  <= ADDR_W'(wr_row) * ADDR_W'(WPR);
          fb_wdata <= row_sr[WORD_W-1:0];
          row_sr   <= row_sr >> WORD_W;
          state    <= WRITE;
        end
        WRITE: begin
          if (fb_ready) begin
            if (last_word) begin
              fb_we  <= 1'b0;
              state  <= IDLE;
              wr_row <= next_row;
              if (row_wrap) begin
                frame_done <= 1'b1;
                wrapped    <= 1'b1;
              end
              if (row_wrap || wrapped) top_row <= next_row;
            end else begin
              word     <= word + WIDX_W'(1);
              fb_addr  <= fb_addr + ADDR_W'(1);
              fb_wdata <= row_sr[WORD_W-1:0];
              row_sr   <= row_sr >> WORD_W;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_row_writer.sv
// Self-checking bench: a default-size writer for streaming/backpressure/reset
// behaviour and a 4-row, 128-bit-word writer for wrap and scroll.
module tb_ca_row_writer;

  logic         clk;
  logic         reset;

  logic         load;
  logic [511:0] ca_row;
  logic         ack;
  logic         fb_we;
  logic [12:0]  fb_addr;
  logic [31:0]  fb_wdata;
  logic         fb_ready;
  logic [8:0]   top_row;
  logic         frame_done;
  logic         busy;

  logic         b_load;
  logic [511:0] b_ca_row;
  logic         b_ack;
  logic         b_we;
  logic [3:0]   b_addr;
  logic [127:0] b_wdata;
  logic         b_ready;
  logic [1:0]   b_top;
  logic         b_fd;
  logic         b_busy;

  ca_row_writer dut_a (
    .clk(clk), .reset(reset), .load(load), .ca_row(ca_row), .ack(ack),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_ready(fb_ready),
    .top_row(top_row), .frame_done(frame_done), .busy(busy)
  );

  ca_row_writer #(.ROW_W(512), .WORD_W(128), .ROWS(4)) dut_b (
    .clk(clk), .reset(reset), .load(b_load), .ca_row(b_ca_row), .ack(b_ack),
    .fb_we(b_we), .fb_addr(b_addr), .fb_wdata(b_wdata), .fb_ready(b_ready),
    .top_row(b_top), .frame_done(b_fd), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame-buffer writes of dut_a, in acceptance order.
  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int          ack_cnt = 0;
  int          fd_cnt = 0;
  int          b_fd_cnt = 0;
  logic        a_stall = 1'b0;
  logic [12:0] h_addr = '0;
  logic [31:0] h_data = '0;

  // Write monitor for dut_a: every accepted write must be the next expected
  // one, and a stalled write must be held unchanged.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (reset) begin
        a_stall = 1'b0;
      end else begin
        if (ack) ack_cnt++;
        if (frame_done) fd_cnt++;
        if (b_fd) b_fd_cnt++;
        if (a_stall) begin
          check("hold_we", 128'(fb_we), 128'(1'b1));
          check("hold_addr", 128'(fb_addr), 128'(h_addr));
          check("hold_data", 128'(fb_wdata), 128'(h_data));
        end
        if (fb_we && fb_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_write: actual addr=%0h data=%0h required no write", fb_addr, fb_wdata);
          end else begin
            w = exp_q.pop_front();
            check("wr_addr", 128'(fb_addr), 128'(w.addr));
            check("wr_data", 128'(fb_wdata), 128'(w.data));
          end
        end
        a_stall = fb_we && !fb_ready;
        h_addr  = fb_addr;
        h_data  = fb_wdata;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int n_a = 0;   // rows completed by dut_a since reset
  int n_b = 0;   // rows completed by dut_b since reset

  function automatic logic [511:0] rand_row();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int exp_top(input int n, input int rows);
    return (n >= rows) ? (n % rows) : 0;
  endfunction

  task automatic idle_check(input string tag);
    check({tag, "_ack"}, 128'(ack), 128'(1'b0));
    check({tag, "_we"}, 128'(fb_we), 128'(1'b0));
    check({tag, "_busy"}, 128'(busy), 128'(1'b0));
    check({tag, "_frame_done"}, 128'(frame_done), 128'(1'b0));
  endtask

  // One full row on dut_a; called at posedge+2 with dut_a idle.
  task automatic send_row_a(input logic [511:0] row, input int pct, input bit scramble);
    int ri;
    int acks0;
    int cyc;
    ri = n_a % 512;
    for (int k = 0; k < 16; k++)
      exp_q.push_back(wr_t'{addr: 13'(ri * 16 + k), data: row[k*32 +: 32]});
    acks0    = ack_cnt;
    ca_row   = row;
    load     = 1'b1;
    fb_ready = ($urandom_range(99) < pct);
    @(posedge clk); #2;
    check("ack_latency", 128'(ack), 128'(1'b1));
    check("busy_in_ack", 128'(busy), 128'(1'b1));
    load = 1'b0;
    cyc  = 0;
    while (busy && cyc < 2000) begin
      fb_ready = ($urandom_range(99) < pct);
      if (scramble) begin
        ca_row = rand_row();
        load   = (exp_q.size() >= 2) ? 1'($urandom_range(1)) : 1'b0;
      end
      @(posedge clk); #2;
      cyc++;
    end
    load = 1'b0;
    n_a++;
    check("row_in_time", 128'(cyc < 2000), 128'(1'b1));
    check("row_words_left", 128'(exp_q.size()), 128'(0));
    check("row_frame_done", 128'(frame_done), 128'(n_a % 512 == 0));
    check("row_top_row", 128'(top_row), 128'(exp_top(n_a, 512)));
    @(negedge clk);
    check("ack_once", 128'(ack_cnt - acks0), 128'(1));
    @(posedge clk); #2;
  endtask

  // One full row on dut_b with random backpressure; writes are checked inline.
  task automatic send_row_b(input logic [511:0] row);
    int ri;
    int k;
    int cyc;
    ri       = n_b % 4;
    k        = 0;
    b_ca_row = row;
    b_load   = 1'b1;
    b_ready  = 1'b1;
    @(posedge clk); #2;
    check("b_ack", 128'(b_ack), 128'(1'b1));
    b_load = 1'b0;
    cyc    = 0;
    while (b_busy && cyc < 200) begin
      b_ready = 1'($urandom_range(1));
      if (b_we && b_ready) begin
        check("b_addr", 128'(b_addr), 128'(ri * 4 + k));
        check("b_data", b_wdata, row[k*128 +: 128]);
        k++;
      end
      @(posedge clk); #2;
      cyc++;
    end
    n_b++;
    check("b_in_time", 128'(cyc < 200), 128'(1'b1));
    check("b_words", 128'(k), 128'(4));
    check("b_frame_done", 128'(b_fd), 128'(n_b % 4 == 0));
    check("b_top_row", 128'(b_top), 128'(exp_top(n_b, 4)));
    @(posedge clk); #2;
    check("b_frame_done_pulse", 128'(b_fd), 128'(1'b0));
  endtask

  typedef struct {
    logic        load;
    logic        ready;
    logic        ack;
    logic        we;
    logic        busy;
    logic [12:0] addr;
    logic [31:0] data;
  } vec_t;

  initial begin
    vec_t         vt[19];
    logic [511:0] row0;
    int           acks0;
    int           cyc;

    // Single-row vectors: capture, ack, 16 streamed words, back to idle.
    vt[0] = '{load: 1'b1, ready: 1'b1, ack: 1'b1, we: 1'b0, busy: 1'b1, addr: 13'd0, data: 32'd0};
    vt[1] = '{load: 1'b0, ready: 1'b1, ack: 1'b0, we: 1'b1, busy: 1'b1, addr: 13'd0, data: 32'hC0DE_0000};
    for (int k = 1; k < 16; k++)
      vt[k+1] = '{load: 1'b0, ready: 1'b1, ack: 1'b0, we: 1'b1, busy: 1'b1,
                  addr: 13'(k), data: 32'hC0DE_0000 + 32'(k)};
    vt[17] = '{load: 1'b0, ready: 1'b1, ack: 1'b0, we: 1'b0, busy: 1'b0, addr: 13'd0, data: 32'd0};
    vt[18] = '{load: 1'b0, ready: 1'b0, ack: 1'b0, we: 1'b0, busy: 1'b0, addr: 13'd0, data: 32'd0};
    for (int k = 0; k < 16; k++) row0[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);

    reset    = 1'b0;
    load     = 1'b0;
    ca_row   = '0;
    fb_ready = 1'b0;
    b_load   = 1'b0;
    b_ca_row = '0;
    b_ready  = 1'b0;

    // Reset asserted mid-cycle, outputs must clear without a clock edge.
    #3 reset = 1'b1;
    #1;
    idle_check("rst_async");
    check("rst_top_row", 128'(top_row), 128'(0));
    check("rst_addr", 128'(fb_addr), 128'(0));
    check("rst_wdata", 128'(fb_wdata), 128'(0));
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      idle_check("rst_idle");
      check("rst_idle_top_row", 128'(top_row), 128'(0));
    end

    // Single row through the vector table.
    ca_row = row0;
    for (int k = 0; k < 16; k++)
      exp_q.push_back(wr_t'{addr: 13'(k), data: row0[k*32 +: 32]});
    acks0 = ack_cnt;
    for (int i = 0; i < 19; i++) begin
      load     = vt[i].load;
      fb_ready = vt[i].ready;
      @(posedge clk); #2;
      check("vec_ack", 128'(ack), 128'(vt[i].ack));
      check("vec_we", 128'(fb_we), 128'(vt[i].we));
      check("vec_busy", 128'(busy), 128'(vt[i].busy));
      if (vt[i].we) begin
        check("vec_addr", 128'(fb_addr), 128'(vt[i].addr));
        check("vec_data", 128'(fb_wdata), 128'(vt[i].data));
      end
    end
    n_a = 1;
    check("vec_words_left", 128'(exp_q.size()), 128'(0));
    check("vec_ack_once", 128'(ack_cnt - acks0), 128'(1));
    check("vec_top_row", 128'(top_row), 128'(0));

    // Backpressure on row 1 (addresses 16..31).
    send_row_a(rand_row(), 50, 1'b0);

    // load toggling and ca_row changing while writing.
    for (int r = 0; r < 4; r++) send_row_a(rand_row(), 40 + 20 * r, 1'b1);

    // Reset after word 5 of a row has been accepted.
    for (int k = 0; k < 16; k++)
      exp_q.push_back(wr_t'{addr: 13'((n_a % 512) * 16 + k), data: 32'hAB00_0000 + 32'(k)});
    for (int k = 0; k < 16; k++) ca_row[k*32 +: 32] = 32'hAB00_0000 + 32'(k);
    load     = 1'b1;
    fb_ready = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
    cyc  = 0;
    while (exp_q.size() > 10 && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("mid_reached_word6", 128'(exp_q.size()), 128'(10));
    check("mid_we_before_reset", 128'(fb_we), 128'(1'b1));
    reset = 1'b1;
    #1;
    check("mid_we_async_drop", 128'(fb_we), 128'(1'b0));
    check("mid_busy_drop", 128'(busy), 128'(1'b0));
    exp_q.delete();
    n_a   = 0;
    acks0 = ack_cnt;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      idle_check("post_reset");
    end
    check("post_reset_no_ack", 128'(ack_cnt - acks0), 128'(0));
    send_row_a(rand_row(), 100, 1'b0);

    // Wrap and scroll on the 4-row instance.
    for (int r = 0; r < 6; r++) send_row_b(rand_row());
    @(negedge clk);
    check("b_frame_done_count", 128'(b_fd_cnt), 128'(1));
    check("a_frame_done_count", 128'(fd_cnt), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
